// File: rtl/trace_player.sv
// Trace-replay engine: takes pre-parsed trace records (read, write,
// read-modify-write, idle) and turns each memory record into a sequence of
// word-aligned single-word strobes on the memory port, with saturating
// busy-cycle and access counters.
module trace_player #(
    parameter int ADDR_WIDTH  = 64,
    parameter int WORD_SHIFT  = 3,
    parameter int SIZE_WIDTH  = 32,
    parameter int COUNT_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_action,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [SIZE_WIDTH-1:0]  cmd_size,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_re,
    output logic                   mem_we,
    input  logic                   mem_ready,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic [COUNT_WIDTH-1:0] read_count,
    output logic [COUNT_WIDTH-1:0] write_count
);

    // Wide enough that size + byte offset + rounding never overflows.
    localparam int CNT_W     = SIZE_WIDTH + WORD_SHIFT + 1;
    localparam int WORD_SIZE = 1 << WORD_SHIFT;

    localparam logic [1:0] ACT_READ   = 2'd0;
    localparam logic [1:0] ACT_WRITE  = 2'd1;
    localparam logic [1:0] ACT_MODIFY = 2'd2;
    localparam logic [1:0] ACT_IDLE   = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_R,
        WAIT_R,
        ISSUE_W,
        WAIT_W,
        IDLE_CNT
    } state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        remaining, remaining_next, remaining_dec;
    logic                    modify, modify_next;
    logic [ADDR_WIDTH-1:0]   addr_next, addr_step, addr_aligned;
    logic [CNT_W-1:0]        size_ext, offset_ext, word_count;

    // Word count covers the partial first word created by an unaligned start.
    assign size_ext     = CNT_W'(cmd_size);
    assign offset_ext   = CNT_W'(cmd_addr & ADDR_WIDTH'(WORD_SIZE - 1));
    assign word_count   = (size_ext + offset_ext + CNT_W'(WORD_SIZE - 1)) >> WORD_SHIFT;
    assign addr_aligned = cmd_addr & ~ADDR_WIDTH'(WORD_SIZE - 1);
    assign addr_step    = mem_addr + ADDR_WIDTH'(WORD_SIZE);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // State and record-tracking registers; reset discards any record in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            modify    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            modify    <= modify_next;
            mem_addr  <= addr_next;
        end
    end

    // Next-state logic and single-cycle strobes gated by mem_ready.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        modify_next    = modify;
        addr_next      = mem_addr;
        mem_re         = 1'b0;
        mem_we         = 1'b0;
        remaining_dec  = remaining - CNT_W'(1);
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_size != '0) begin
                    if (cmd_action == ACT_IDLE) begin
                        remaining_next = size_ext;
                        state_next     = IDLE_CNT;
                    end else begin
                        remaining_next = word_count;
                        addr_next      = addr_aligned;
                        modify_next    = (cmd_action == ACT_MODIFY);
                        state_next     = (cmd_action == ACT_WRITE) ? ISSUE_W : ISSUE_R;
                    end
                end
            end
            ISSUE_R: begin
                if (mem_ready) begin
                    mem_re     = 1'b1;
                    state_next = WAIT_R;
                end
            end
            WAIT_R: begin
                if (mem_ready) begin
                    if (modify) begin
                        state_next = ISSUE_W;
                    end else begin
                        remaining_next = remaining_dec;
                        if (remaining_dec != '0) begin
                            addr_next  = addr_step;
                            state_next = ISSUE_R;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            ISSUE_W: begin
                if (mem_ready) begin
                    mem_we     = 1'b1;
                    state_next = WAIT_W;
                end
            end
            WAIT_W: begin
                if (mem_ready) begin
                    remaining_next = remaining_dec;
                    if (remaining_dec != '0) begin
                        addr_next  = addr_step;
                        state_next = modify ? ISSUE_R : ISSUE_W;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            IDLE_CNT: begin
                remaining_next = remaining_dec;
                if (remaining_dec == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= '0;
            read_count  <= '0;
            write_count <= '0;
        end else begin
            if (busy && cycle_count != '1) begin
                cycle_count <= cycle_count + COUNT_WIDTH'(1);
            end
            if (mem_re && read_count != '1) begin
                read_count <= read_count + COUNT_WIDTH'(1);
            end
            if (mem_we && write_count != '1) begin
                write_count <= write_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_trace_player.sv
// Self-checking bench for trace_player: directed records plus randomized
// records compared against an access-list model of the replay rules.
module tb_trace_player;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_action = 2'd0;
    logic [63:0] cmd_addr = '0;
    logic [31:0] cmd_size = '0;
    logic [63:0] mem_addr;
    logic        mem_re, mem_we;
    logic        mem_ready = 1'b1;
    logic        busy;
    logic [63:0] cycle_count, read_count, write_count;

    int          checks = 0;
    int          fails = 0;
    int          overlap_n = 0;
    int          ready_mode = 1;
    int          track_cycles = 1;
    longint      cyc = 0;
    logic [64:0] obs_q[$];
    longint      obs_t[$];
    logic [64:0] exp_q[$];
    logic [63:0] exp_reads = '0;
    logic [63:0] exp_writes = '0;
    logic [63:0] exp_cycles = '0;

    trace_player dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_action(cmd_action), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_ready(mem_ready), .busy(busy),
        .cycle_count(cycle_count), .read_count(read_count), .write_count(write_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe seen on the memory port.
    always @(negedge clk) begin
        if (rst) begin
            if (mem_re && mem_we) overlap_n++;
            if (mem_re) begin obs_q.push_back({1'b0, mem_addr}); obs_t.push_back(cyc); end
            if (mem_we) begin obs_q.push_back({1'b1, mem_addr}); obs_t.push_back(cyc); end
        end
    end

    // Memory readiness: forced low, forced high, or random per cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       mem_ready = 1'b0;
                1:       mem_ready = 1'b1;
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [64:0] observed, input logic [64:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] wordsOf(input logic [63:0] addr, input logic [31:0] size);
        return (64'(size) + (addr & 64'h7) + 64'd7) >> 3;
    endfunction

    // Busy cycles a record takes when memory is always ready.
    function automatic int expBusy(input logic [1:0] action, input logic [63:0] addr, input logic [31:0] size);
        if (size == 0) return 0;
        if (action == 2'd3) return int'(size);
        if (action == 2'd2) return int'(4 * wordsOf(addr, size));
        return int'(2 * wordsOf(addr, size));
    endfunction

    // Expected access list: one access per word touched, M reads then writes each word.
    task automatic modelRecord(input logic [1:0] action, input logic [63:0] addr, input logic [31:0] size);
        logic [63:0] n;
        logic [63:0] a;
        if (action == 2'd3 || size == 0) return;
        n = wordsOf(addr, size);
        for (longint unsigned i = 0; i < n; i++) begin
            a = (addr & ~64'h7) + 64'(i) * 64'd8;
            if (action != 2'd1) begin exp_q.push_back({1'b0, a}); exp_reads++; end
            if (action != 2'd0) begin exp_q.push_back({1'b1, a}); exp_writes++; end
        end
    endtask

    task automatic compareAccesses(input string tag);
        int n;
        checkOutput({tag, "_count"}, 65'(obs_q.size()), 65'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_acc%0d", tag, i), obs_q[i], exp_q[i]);
        end
        obs_q.delete();
        obs_t.delete();
        exp_q.delete();
    endtask

    // Presents one record (entered and left at a negedge with cmd_ready high).
    task automatic applyStimulus(input logic [1:0] action, input logic [63:0] addr, input logic [31:0] size,
                                 output int busy_n, output int notready_n, output int wait_n);
        modelRecord(action, addr, size);
        cmd_action = action;
        cmd_addr   = addr;
        cmd_size   = size;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        busy_n = 0;
        notready_n = 0;
        wait_n = 0;
        do begin
            @(negedge clk);
            if (busy) busy_n++;
            if (!cmd_ready) notready_n++;
            wait_n++;
        end while (!cmd_ready && wait_n < 5000);
        checkOutput("record_finished", 65'(cmd_ready), 65'd1);
    endtask

    task automatic runRecord(input string tag, input logic [1:0] action, input logic [63:0] addr, input logic [31:0] size);
        int b, nr, w;
        applyStimulus(action, addr, size, b, nr, w);
        if (track_cycles != 0) begin
            exp_cycles += 64'(expBusy(action, addr, size));
            checkOutput({tag, "_busy"}, 65'(b), 65'(expBusy(action, addr, size)));
            checkOutput({tag, "_cycles"}, 65'(cycle_count), 65'(exp_cycles));
        end
        compareAccesses(tag);
        checkOutput({tag, "_reads"}, 65'(read_count), 65'(exp_reads));
        checkOutput({tag, "_writes"}, 65'(write_count), 65'(exp_writes));
        checkOutput({tag, "_overlap"}, 65'(overlap_n), 65'd0);
    endtask

    initial begin
        int b, nr, w, cnt_a, cnt_b;
        logic [1:0]  act;
        logic [63:0] addr;
        logic [31:0] size;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_ready", 65'(cmd_ready), 65'd1);
        checkOutput("reset_busy", 65'(busy), 65'd0);
        checkOutput("reset_re", 65'(mem_re), 65'd0);
        checkOutput("reset_we", 65'(mem_we), 65'd0);
        checkOutput("reset_addr", 65'(mem_addr), 65'd0);
        checkOutput("reset_cycles", 65'(cycle_count), 65'd0);
        checkOutput("reset_reads", 65'(read_count), 65'd0);
        checkOutput("reset_writes", 65'(write_count), 65'd0);

        // Unaligned read spanning two words: strobes two cycles apart.
        modelRecord(2'd0, 64'h1004, 32'd8);
        exp_cycles += 64'd4;
        cmd_action = 2'd0; cmd_addr = 64'h1004; cmd_size = 32'd8; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!cmd_ready && w < 100);
        checkOutput("r_busy_cycles", 65'(cycle_count), 65'd4);
        checkOutput("r_gap", 65'((obs_t.size() >= 2) ? obs_t[1] - obs_t[0] : 0), 65'd2);
        compareAccesses("r_split");
        checkOutput("r_reads", 65'(read_count), 65'd2);

        runRecord("modify", 2'd2, 64'h10, 32'd8);

        applyStimulus(2'd3, 64'h0, 32'd5, b, nr, w);
        exp_cycles += 64'd5;
        checkOutput("idle_busy", 65'(b), 65'd5);
        checkOutput("idle_ready_return", 65'(w), 65'd6);
        checkOutput("idle_cycles", 65'(cycle_count), 65'(exp_cycles));
        compareAccesses("idle");

        runRecord("wrap", 2'd1, 64'hFFFF_FFFF_FFFF_FFF8, 32'd16);

        applyStimulus(2'd0, 64'h3, 32'd0, b, nr, w);
        checkOutput("zero_notready", 65'(nr), 65'd0);
        checkOutput("zero_busy", 65'(b), 65'd0);
        compareAccesses("zero");
        checkOutput("zero_reads", 65'(read_count), 65'(exp_reads));

        // Randomized records, memory always ready.
        for (int i = 0; i < 16; i++) begin
            act  = 2'($urandom_range(0, 3));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) addr = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
            size = (act == 2'd3) ? 32'($urandom_range(0, 12)) : 32'($urandom_range(0, 40));
            runRecord($sformatf("rnd%0d", i), act, addr, size);
        end

        // Stalls: strobe waits for ready, completion waits for ready.
        track_cycles = 0;
        ready_mode = 0;
        @(negedge clk);
        @(negedge clk);
        modelRecord(2'd0, 64'h200, 32'd8);
        cmd_action = 2'd0; cmd_addr = 64'h200; cmd_size = 32'd8; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cnt_a = 0; cnt_b = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_re) cnt_a++;
            if (!busy) cnt_b++;
        end
        checkOutput("stall_issue_no_strobe", 65'(cnt_a), 65'd0);
        checkOutput("stall_issue_busy", 65'(cnt_b), 65'd0);
        ready_mode = 1;
        @(negedge clk);
        checkOutput("stall_strobe_on_ready", 65'(mem_re), 65'd1);
        ready_mode = 0;
        cnt_a = 0; cnt_b = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_re) cnt_a++;
            if (cmd_ready) cnt_b++;
        end
        checkOutput("stall_wait_no_strobe", 65'(cnt_a), 65'd0);
        checkOutput("stall_wait_not_ready", 65'(cnt_b), 65'd0);
        ready_mode = 1;
        w = 0;
        do begin @(negedge clk); w++; end while (!cmd_ready && w < 100);
        checkOutput("stall_release", 65'(w), 65'd2);
        compareAccesses("stall");
        checkOutput("stall_reads", 65'(read_count), 65'(exp_reads));

        // Randomized records with random memory readiness.
        ready_mode = 2;
        for (int i = 0; i < 16; i++) begin
            act  = 2'($urandom_range(0, 3));
            addr = {$urandom, $urandom};
            size = (act == 2'd3) ? 32'($urandom_range(0, 12)) : 32'($urandom_range(0, 40));
            runRecord($sformatf("rr%0d", i), act, addr, size);
        end

        // Asynchronous reset while waiting on a read.
        ready_mode = 0;
        @(negedge clk);
        @(negedge clk);
        cmd_action = 2'd0; cmd_addr = 64'h300; cmd_size = 32'd16; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        ready_mode = 1;
        @(negedge clk);
        ready_mode = 0;
        @(negedge clk);
        checkOutput("prereset_busy", 65'(busy), 65'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("midreset_re", 65'(mem_re), 65'd0);
        checkOutput("midreset_busy", 65'(busy), 65'd0);
        checkOutput("midreset_reads", 65'(read_count), 65'd0);
        checkOutput("midreset_writes", 65'(write_count), 65'd0);
        checkOutput("midreset_cycles", 65'(cycle_count), 65'd0);
        @(negedge clk);
        rst = 1'b1;
        ready_mode = 1;
        obs_q.delete();
        obs_t.delete();
        exp_q.delete();
        @(negedge clk);
        checkOutput("postreset_ready", 65'(cmd_ready), 65'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
